fn_sw_arb: RTL and testbench

//  Two-requester round-robin arbiter/sequencer for the fn_sw 2:1 switch.

---
 rtl/fn_sw_arb.sv | 134 +++++++++++++
 tb/tb_fn_sw_arb.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fn_sw_arb.sv
// Two-requester round-robin arbiter for the fn_sw 2:1 switch: burst grants,
// a one-cycle dead gap on ownership change, and registered data out.
// Optional switch counter: define FN_SW_ARB_STAT_EN to add the sw_cnt output.
module fn_sw_arb #(
  parameter int DW        = 1,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic          req_b,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          sel,
  output logic [DW-1:0] y,
  output logic          y_vld,
  output logic          busy
`ifdef FN_SW_ARB_STAT_EN
  ,
  output logic [15:0]   sw_cnt
`endif
);

  localparam int CW = $clog2(MAX_BURST);
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, GAP} state_t;

  // Handshake: a channel may drive data while req_x=1; a sample is transferred
  // on every cycle where gnt_x=1 and req_x=1, and appears on y one cycle later.
  state_t          state, state_n;
  logic [CW-1:0]   burst_cnt, cnt_n;
  logic            last_owner, last_n;  // 0 = A, 1 = B
  logic            sel_q, sel_n;
  logic [DW-1:0]   y_q;
  logic            vld_q;
  logic            take;

  always_comb begin
    state_n = state;
    cnt_n   = burst_cnt;
    last_n  = last_owner;
    sel_n   = sel_q;
    case (state)
      IDLE: begin
        if (req_a && (!req_b || last_owner)) begin
          state_n = OWN_A;
          sel_n   = 1'b0;
          cnt_n   = '0;
        end else if (req_b) begin
          state_n = OWN_B;
          sel_n   = 1'b1;
          cnt_n   = '0;
        end
      end
      OWN_A: begin
        if (req_a && burst_cnt != LAST) begin
          cnt_n = burst_cnt + 1'b1;
        end else if (req_b) begin
          state_n = GAP;
          last_n  = 1'b0;
          sel_n   = 1'b1;
          cnt_n   = '0;
        end else if (req_a) begin
          cnt_n = '0;
        end else begin
          state_n = IDLE;
          last_n  = 1'b0;
          cnt_n   = '0;
        end
      end
      OWN_B: begin
        if (req_b && burst_cnt != LAST) begin
          cnt_n = burst_cnt + 1'b1;
        end else if (req_a) begin
          state_n = GAP;
          last_n  = 1'b1;
          sel_n   = 1'b0;
          cnt_n   = '0;
        end else if (req_b) begin
          cnt_n = '0;
        end else begin
          state_n = IDLE;
          last_n  = 1'b1;
          cnt_n   = '0;
        end
      end
      GAP: begin
        // sel already points at the incoming owner; bail to IDLE if it gave up.
        cnt_n = '0;
        if (sel_q ? req_b : req_a) state_n = sel_q ? OWN_B : OWN_A;
        else                       state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign take = (state == OWN_A && req_a) || (state == OWN_B && req_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_owner <= 1'b1;
      sel_q      <= 1'b0;
      y_q        <= '0;
      vld_q      <= 1'b0;
    end else begin
      state      <= state_n;
      burst_cnt  <= cnt_n;
      last_owner <= last_n;
      sel_q      <= sel_n;
      vld_q      <= take;
      if (take) y_q <= sel_q ? b : a;
    end
  end

`ifdef FN_SW_ARB_STAT_EN
  always_ff @(posedge clk) begin
    if (rst)                                                        sw_cnt <= '0;
    else if (state_n == GAP && state != GAP && sw_cnt != 16'hFFFF) sw_cnt <= sw_cnt + 16'd1;
  end
`endif

  assign gnt_a = (state == OWN_A);
  assign gnt_b = (state == OWN_B);
  assign sel   = sel_q;
  assign y     = y_q;
  assign y_vld = vld_q;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_fn_sw_arb.sv
// Directed bench for fn_sw_arb: a cycle model predicts every output, expected
// vectors are queued at drive time and checked one edge later.
module tb_fn_sw_arb;
  localparam int DW        = 4;
  localparam int MAX_BURST = 8;
  localparam int W         = DW + 21;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, req_a, req_b;
  logic [DW-1:0] a, b;
  logic          gnt_a, gnt_b, sel, y_vld, busy;
  logic [DW-1:0] y;
`ifdef FN_SW_ARB_STAT_EN
  logic [15:0]   sw_cnt;
`endif

  fn_sw_arb #(.DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel), .y(y), .y_vld(y_vld), .busy(busy)
`ifdef FN_SW_ARB_STAT_EN
    , .sw_cnt(sw_cnt)
`endif
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // reference model state: 0 idle, 1 own A, 2 own B, 3 gap
  int            m_st;
  int            m_cnt;
  logic          m_last, m_sel, m_vld;
  logic [DW-1:0] m_y;
  logic [15:0]   m_sw;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_last = 1'b1; m_sel = 1'b0; m_vld = 1'b0; m_y = '0; m_sw = '0;
  endtask

  task automatic model_step(input logic ra, input logic rb, input logic [DW-1:0] da,
                            input logic [DW-1:0] db);
    logic own, rq, ro;
    m_vld = (m_st == 1 && ra) || (m_st == 2 && rb);
    if (m_vld) m_y = m_sel ? db : da;
    case (m_st)
      0: if (ra || rb) begin
           own   = (ra && rb) ? !m_last : rb;
           m_st  = own ? 2 : 1;
           m_sel = own;
           m_cnt = 0;
         end
      1, 2: begin
        own = (m_st == 2);
        rq  = own ? rb : ra;
        ro  = own ? ra : rb;
        if (rq && m_cnt < MAX_BURST - 1) m_cnt++;
        else if (ro) begin
          m_st = 3; m_last = own; m_sel = !own; m_cnt = 0;
          if (m_sw != 16'hFFFF) m_sw++;
        end else if (rq) m_cnt = 0;
        else begin
          m_st = 0; m_last = own; m_cnt = 0;
        end
      end
      default: begin
        m_cnt = 0;
        m_st  = (m_sel ? rb : ra) ? (m_sel ? 2 : 1) : 0;
      end
    endcase
  endtask

  // driver: apply one cycle, queue the prediction, compare after the edge
  task automatic drive(input logic r, input logic ra, input logic rb,
                       input logic [DW-1:0] da, input logic [DW-1:0] db);
    logic [W-1:0] e;
    rst = r; req_a = ra; req_b = rb; a = da; b = db;
    if (r) model_reset();
    else   model_step(ra, rb, da, db);
    exp_q.push_back({m_sw, m_st == 1, m_st == 2, m_sel, m_st != 0, m_vld, m_y});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("gnt_a", 32'(gnt_a), 32'(e[DW+4]));
    check("gnt_b", 32'(gnt_b), 32'(e[DW+3]));
    check("sel",   32'(sel),   32'(e[DW+2]));
    check("busy",  32'(busy),  32'(e[DW+1]));
    check("y_vld", 32'(y_vld), 32'(e[DW]));
    check("y",     32'(y),     32'(e[DW-1:0]));
    check("gnt_mutex", 32'(gnt_a & gnt_b), 32'd0);
`ifdef FN_SW_ARB_STAT_EN
    check("sw_cnt", 32'(sw_cnt), 32'(e[W-1:DW+5]));
`endif
  endtask

  function automatic logic [DW-1:0] rnd();
    return DW'($urandom_range(0, (1 << DW) - 1));
  endfunction

  int cnt_a, cnt_b, cnt_gap, drops;

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; a = '0; b = '0;
    model_reset();

    // 1: reset held two cycles, no requests
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_y",    32'(y),    32'd0);

    // 2: A alone, a=1: grant next cycle, data one cycle after that
    drive(0, 1, 0, 4'h1, 4'h0);
    check("s2_gnt_a", 32'(gnt_a), 32'd1);
    check("s2_vld0",  32'(y_vld), 32'd0);
    drive(0, 1, 0, 4'h1, 4'h0);
    check("s2_y",     32'(y),     32'd1);
    check("s2_vld1",  32'(y_vld), 32'd1);
    for (int i = 0; i < 2; i++) drive(0, 1, 0, rnd(), rnd());
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // 3: both requesting from a fresh reset -> A first, 8-cycle bursts with gaps
    drive(1, 0, 0, 0, 0);
    cnt_a = 0; cnt_b = 0; cnt_gap = 0;
    for (int i = 0; i < 40; i++) begin
      drive(0, 1, 1, rnd(), rnd());
      if (i == 0) check("s3_first_a", 32'(gnt_a), 32'd1);
      cnt_a   += int'(gnt_a);
      cnt_b   += int'(gnt_b);
      cnt_gap += int'(busy && !gnt_a && !gnt_b);
    end
    check("s3_a_cycles", 32'(cnt_a),   32'd20);
    check("s3_b_cycles", 32'(cnt_b),   32'd16);
    check("s3_gaps",     32'(cnt_gap), 32'd4);
`ifdef FN_SW_ARB_STAT_EN
    check("s3_sw_cnt", 32'(sw_cnt), 32'd4);
`endif
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // 4: A owning, A drops at cycle 3 while B requests -> gap, sel flips, B granted
    drive(0, 1, 0, rnd(), rnd());
    drive(0, 1, 1, rnd(), rnd());
    drive(0, 1, 1, rnd(), rnd());
    drive(0, 0, 1, rnd(), rnd());
    check("s4_gap_sel",  32'(sel),   32'd1);
    check("s4_gap_gnt",  32'(gnt_a | gnt_b), 32'd0);
    drive(0, 0, 1, rnd(), rnd());
    check("s4_gnt_b",    32'(gnt_b), 32'd1);
    drive(0, 0, 0, 0, 0);

    // 5: A alone for 20 cycles -> continuous grant, no gap
    drops = 0;
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 0, rnd(), rnd());
      drops += int'(!gnt_a);
    end
    check("s5_no_drop", 32'(drops), 32'd0);
    drive(0, 0, 0, 0, 0);

    // 6: reset mid-burst with B owning and y=all ones
    for (int i = 0; i < 3; i++) drive(0, 0, 1, rnd(), 4'hF);
    check("s6_pre_y", 32'(y), 32'hF);
    drive(1, 0, 1, rnd(), 4'hF);
    check("s6_gnt_b", 32'(gnt_b), 32'd0);
    check("s6_sel",   32'(sel),   32'd0);
    check("s6_y",     32'(y),     32'd0);
    check("s6_vld",   32'(y_vld), 32'd0);

    // random traffic, including requesters dropping during a gap
    for (int i = 0; i < 200; i++)
      drive(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), rnd(), rnd());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
